// File: rtl/csi_tx_packet_assembler.sv
// CSI-2 TX packet assembler: frames showahead-FIFO line data into FS / long line / FE
// packets and streams them as 32-bit words through a single valid/ready output register.
module csi_tx_packet_assembler #(
    parameter int unsigned LINE_BYTES      = 640,
    parameter int unsigned LINES_PER_FRAME = 480,
    parameter logic [5:0]  DATA_TYPE       = 6'h24,
    parameter logic [1:0]  VIRTUAL_CHANNEL = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] fifo_data,
    input  logic        fifo_not_empty,
    input  logic        fifo_line_ready,
    output logic        fifo_read_ack,
    output logic [31:0] pkt_data,
    output logic        pkt_valid,
    input  logic        pkt_ready,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic [1:0]  pkt_bytes,
    output logic        frame_active
);

    localparam int unsigned WORDS = LINE_BYTES / 4;
    localparam int unsigned WCW   = 14;
    localparam int unsigned LCW   = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FS,
        S_WAIT_LINE,
        S_HDR,
        S_PAYLOAD,
        S_CRC,
        S_FE
    } state_t;

    // CSI-2 Hamming parity over {WC, DI}; each mask selects the data bits feeding one parity bit
    function automatic logic [7:0] f_ecc(input logic [23:0] d);
        logic [7:0] e;
        e    = '0;
        e[0] = ^(d & 24'hF12CB7);
        e[1] = ^(d & 24'hF2555B);
        e[2] = ^(d & 24'h749A6D);
        e[3] = ^(d & 24'hB8E38E);
        e[4] = ^(d & 24'hDF03F0);
        e[5] = ^(d & 24'hEFFC00);
        return e;
    endfunction

    function automatic logic [15:0] f_crc(input logic [15:0] c, input logic [31:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int unsigned i = 0; i < 32; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
        end
        return r;
    endfunction

    state_t           r_state;
    logic [15:0]      r_frame_num;
    logic [LCW-1:0]   r_line_cnt;
    logic [WCW-1:0]   r_word_cnt;
    logic [15:0]      r_crc;
    logic             r_sent;
    logic             r_frame_active;
    logic [31:0]      r_data;
    logic             r_valid;
    logic             r_sop;
    logic             r_eop;
    logic [1:0]       r_bytes;

    logic             w_accept;
    logic             w_can_load;
    logic             w_pop;
    logic [15:0]      w_crc_next;
    logic [31:0]      w_fs_word;
    logic [31:0]      w_fe_word;
    logic [31:0]      w_hdr_word;
    logic             w_load;
    logic [31:0]      w_ld_data;
    logic             w_ld_sop;
    logic             w_ld_eop;
    logic [1:0]       w_ld_bytes;

    assign w_accept   = r_valid & pkt_ready;
    assign w_can_load = ~r_valid | pkt_ready;
    assign w_pop      = (r_state == S_PAYLOAD) & w_can_load & fifo_not_empty;
    assign w_crc_next = f_crc(r_crc, fifo_data);

    assign w_fs_word  = {f_ecc({r_frame_num, VIRTUAL_CHANNEL, 6'h00}), r_frame_num,
                         VIRTUAL_CHANNEL, 6'h00};
    assign w_fe_word  = {f_ecc({r_frame_num, VIRTUAL_CHANNEL, 6'h01}), r_frame_num,
                         VIRTUAL_CHANNEL, 6'h01};
    assign w_hdr_word = {f_ecc({16'(LINE_BYTES), VIRTUAL_CHANNEL, DATA_TYPE}),
                         16'(LINE_BYTES), VIRTUAL_CHANNEL, DATA_TYPE};

    assign fifo_read_ack = w_pop;
    assign pkt_data      = r_data;
    assign pkt_valid     = r_valid;
    assign pkt_sop       = r_sop;
    assign pkt_eop       = r_eop;
    assign pkt_bytes     = r_bytes;
    assign frame_active  = r_frame_active;

    // Selects the word (if any) entering the output register this cycle
    always_comb begin
        w_load     = 1'b0;
        w_ld_data  = '0;
        w_ld_sop   = 1'b0;
        w_ld_eop   = 1'b0;
        w_ld_bytes = '0;
        case (r_state)
            S_FS: begin
                if (!r_sent && w_can_load) begin
                    w_load    = 1'b1;
                    w_ld_data = w_fs_word;
                    w_ld_sop  = 1'b1;
                    w_ld_eop  = 1'b1;
                end
            end
            S_HDR: begin
                if (w_can_load) begin
                    w_load    = 1'b1;
                    w_ld_data = w_hdr_word;
                    w_ld_sop  = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (w_pop) begin
                    w_load    = 1'b1;
                    w_ld_data = fifo_data;
                end
            end
            S_CRC: begin
                if (w_can_load) begin
                    w_load     = 1'b1;
                    w_ld_data  = {16'h0000, r_crc};
                    w_ld_eop   = 1'b1;
                    w_ld_bytes = 2'd2;
                end
            end
            S_FE: begin
                if (!r_sent && w_can_load) begin
                    w_load    = 1'b1;
                    w_ld_data = w_fe_word;
                    w_ld_sop  = 1'b1;
                    w_ld_eop  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_frame_num    <= '0;
            r_line_cnt     <= '0;
            r_word_cnt     <= '0;
            r_crc          <= 16'hFFFF;
            r_sent         <= 1'b0;
            r_frame_active <= 1'b0;
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_sop          <= 1'b0;
            r_eop          <= 1'b0;
            r_bytes        <= '0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_load) begin
                r_data  <= w_ld_data;
                r_valid <= 1'b1;
                r_sop   <= w_ld_sop;
                r_eop   <= w_ld_eop;
                r_bytes <= w_ld_bytes;
            end

            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_frame_num <= (r_frame_num == 16'hFFFF) ? 16'd1 : r_frame_num + 16'd1;
                        r_sent      <= 1'b0;
                        r_state     <= S_FS;
                    end
                end
                // FS/FE hold the state until their own word is accepted; r_sent marks it loaded
                S_FS: begin
                    if (w_load) begin
                        r_sent <= 1'b1;
                    end else if (r_sent && w_accept) begin
                        r_sent         <= 1'b0;
                        r_frame_active <= 1'b1;
                        r_state        <= S_WAIT_LINE;
                    end
                end
                S_WAIT_LINE: begin
                    if (fifo_line_ready) begin
                        r_state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_load) begin
                        r_crc      <= 16'hFFFF;
                        r_word_cnt <= '0;
                        r_state    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_load) begin
                        r_crc      <= w_crc_next;
                        r_word_cnt <= r_word_cnt + 1'b1;
                        if (r_word_cnt == WCW'(WORDS - 1)) begin
                            r_state <= S_CRC;
                        end
                    end
                end
                S_CRC: begin
                    if (w_load) begin
                        r_line_cnt <= r_line_cnt + 1'b1;
                        r_sent     <= 1'b0;
                        if (r_line_cnt == LCW'(LINES_PER_FRAME - 1)) begin
                            r_state <= S_FE;
                        end else begin
                            r_state <= S_WAIT_LINE;
                        end
                    end
                end
                S_FE: begin
                    if (w_load) begin
                        r_sent <= 1'b1;
                    end else if (r_sent && w_accept) begin
                        r_sent         <= 1'b0;
                        r_frame_active <= 1'b0;
                        r_line_cnt     <= '0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csi_tx_packet_assembler.sv
// Directed bench for csi_tx_packet_assembler: 8-byte lines, 2 lines per frame, four frames
// covering plain streaming, output backpressure, FIFO underflow and frame-number wrap.
module tb_csi_tx_packet_assembler;

    localparam int unsigned LB  = 8;
    localparam int unsigned LPF = 2;

    // Syndrome column of each {WC, DI} bit in the CSI-2 ECC
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  bytes;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] fifo_data;
    logic        fifo_not_empty;
    logic        fifo_line_ready;
    logic        fifo_read_ack;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [1:0]  pkt_bytes;
    logic        frame_active;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] fmem [0:63];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        uf_mask = 1'b0;
    logic        bp_en = 1'b0;
    logic [15:0] lfsr = 16'hACE1;

    logic [31:0] cap_data [0:63];
    logic [3:0]  cap_ctl  [0:63];
    int unsigned cap_n = 0;
    int unsigned ack_n = 0;

    logic [31:0] dw [4];
    exp_t        exp_tbl [10];

    always #5 clk = ~clk;

    csi_tx_packet_assembler #(
        .LINE_BYTES      (LB),
        .LINES_PER_FRAME (LPF),
        .DATA_TYPE       (6'h24),
        .VIRTUAL_CHANNEL (2'd0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .fifo_data       (fifo_data),
        .fifo_not_empty  (fifo_not_empty),
        .fifo_line_ready (fifo_line_ready),
        .fifo_read_ack   (fifo_read_ack),
        .pkt_data        (pkt_data),
        .pkt_valid       (pkt_valid),
        .pkt_ready       (pkt_ready),
        .pkt_sop         (pkt_sop),
        .pkt_eop         (pkt_eop),
        .pkt_bytes       (pkt_bytes),
        .frame_active    (frame_active)
    );

    assign fifo_data       = fmem[rd_ptr[5:0]];
    assign fifo_not_empty  = (wr_ptr != rd_ptr) && !uf_mask;
    assign fifo_line_ready = (wr_ptr - rd_ptr) >= LB / 4;

    function automatic logic [7:0] m_ecc(input logic [23:0] d);
        logic [5:0] e;
        e = '0;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) e = e ^ ECC_COL[i];
        end
        return {2'b00, e};
    endfunction

    // Byte-wise reflected CRC-16 (0x8408), byte0 first
    function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] x;
        x = c;
        for (int b = 0; b < 4; b++) begin
            x = x ^ {8'h00, w[8*b +: 8]};
            for (int k = 0; k < 8; k++) begin
                x = x[0] ? ((x >> 1) ^ 16'h8408) : (x >> 1);
            end
        end
        return x;
    endfunction

    function automatic logic [31:0] m_short(input logic [5:0] dt, input logic [15:0] fn);
        return {m_ecc({fn, 2'b00, dt}), fn, 2'b00, dt};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < 4; i++) begin
            fmem[wr_ptr[5:0]] = dw[i];
            wr_ptr++;
        end
    endtask

    task automatic wait_words(input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (cap_n < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (cap_n < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_words: got %0d words, required %0d", cap_n, n);
        end
    endtask

    task automatic wait_frame_active();
        int unsigned k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_active && k < 100);
        chk("frame_active_set", {31'h0, frame_active}, 32'h1);
    endtask

    task automatic check_frame(input int unsigned base, input logic [15:0] fn);
        exp_tbl[0].data = m_short(6'h00, fn);
        exp_tbl[9].data = m_short(6'h01, fn);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("frame%0d_word%0d_data", fn, i), cap_data[base + i], exp_tbl[i].data);
            chk($sformatf("frame%0d_word%0d_sop_eop_bytes", fn, i), {28'h0, cap_ctl[base + i]},
                {28'h0, exp_tbl[i].sop, exp_tbl[i].eop, exp_tbl[i].bytes});
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (fifo_read_ack) rd_ptr <= rd_ptr + 1;
        end
    end

    initial begin
        pkt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                lfsr      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                pkt_ready = lfsr[0];
            end else begin
                pkt_ready = 1'b1;
            end
        end
    end

    // Capture accepted words, check stall stability and that no ack occurs on an empty FIFO
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic [3:0]  prev_ctl;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_ctl   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_stall) begin
                    chk("stall_data_hold", pkt_data, prev_data);
                    chk("stall_valid_sop_eop_bytes_hold",
                        {27'h0, pkt_valid, pkt_sop, pkt_eop, pkt_bytes}, {27'h0, 1'b1, prev_ctl});
                end
                if (pkt_valid && pkt_ready && cap_n < 64) begin
                    cap_data[cap_n] = pkt_data;
                    cap_ctl[cap_n]  = {pkt_sop, pkt_eop, pkt_bytes};
                    cap_n++;
                end
                if (fifo_read_ack) ack_n++;
                if (!fifo_not_empty) chk("ack_while_empty", {31'h0, fifo_read_ack}, 32'h0);
                prev_stall = pkt_valid && !pkt_ready;
                prev_data  = pkt_data;
                prev_ctl   = {pkt_sop, pkt_eop, pkt_bytes};
            end
        end
    end

    initial begin
        logic [31:0] hdr;
        logic [15:0] crc_a;
        logic [15:0] crc_b;
        int unsigned k;

        dw[0] = 32'h04030201;
        dw[1] = 32'h08070605;
        dw[2] = 32'hDEADBEEF;
        dw[3] = 32'h0BADF00D;
        crc_a = m_crc(m_crc(16'hFFFF, dw[0]), dw[1]);
        crc_b = m_crc(m_crc(16'hFFFF, dw[2]), dw[3]);
        hdr   = {m_ecc({16'(LB), 8'h24}), 16'(LB), 8'h24};
        exp_tbl = '{
            '{m_short(6'h00, 16'd1), 1'b1, 1'b1, 2'd0},
            '{hdr,                   1'b1, 1'b0, 2'd0},
            '{dw[0],                 1'b0, 1'b0, 2'd0},
            '{dw[1],                 1'b0, 1'b0, 2'd0},
            '{{16'h0000, crc_a},     1'b0, 1'b1, 2'd2},
            '{hdr,                   1'b1, 1'b0, 2'd0},
            '{dw[2],                 1'b0, 1'b0, 2'd0},
            '{dw[3],                 1'b0, 1'b0, 2'd0},
            '{{16'h0000, crc_b},     1'b0, 1'b1, 2'd2},
            '{m_short(6'h01, 16'd1), 1'b1, 1'b1, 2'd0}
        };

        // Reset with enable high and a full line pair waiting
        rst    = 1'b1;
        enable = 1'b1;
        push_frame();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pkt_valid", {31'h0, pkt_valid}, 32'h0);
        chk("rst_pkt_data", pkt_data, 32'h0);
        chk("rst_sop_eop_bytes", {28'h0, pkt_sop, pkt_eop, pkt_bytes}, 32'h0);
        chk("rst_frame_active", {31'h0, frame_active}, 32'h0);
        chk("rst_fifo_read_ack", {31'h0, fifo_read_ack}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Frame 1: full throughput; enable dropped as soon as the frame is active
        wait_frame_active();
        enable = 1'b0;
        wait_words(10, 200);
        chk("fs1_hand_value", cap_data[0], 32'h1A000100);
        chk("hdr_hand_value", cap_data[1], 32'h3D000824);
        check_frame(0, 16'd1);
        repeat (30) @(posedge clk);
        chk("no_fs_while_disabled", cap_n, 32'd10);
        chk("frame_active_cleared", {31'h0, frame_active}, 32'h0);
        chk("ack_count_frame1", ack_n, 32'd4);

        // Frame 2: random backpressure
        push_frame();
        bp_en  = 1'b1;
        enable = 1'b1;
        wait_frame_active();
        enable = 1'b0;
        wait_words(20, 600);
        bp_en = 1'b0;
        check_frame(10, 16'd2);

        // Frame 3: FIFO empty for 5 cycles right after the first payload pop
        push_frame();
        enable = 1'b1;
        wait_frame_active();
        enable = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!fifo_read_ack && k < 50);
        chk("first_payload_ack_seen", {31'h0, fifo_read_ack}, 32'h1);
        @(posedge clk);
        #1 uf_mask = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("underflow_no_ack", {31'h0, fifo_read_ack}, 32'h0);
            if (i > 0) chk("underflow_valid_low", {31'h0, pkt_valid}, 32'h0);
        end
        @(posedge clk);
        #1 uf_mask = 1'b0;
        wait_words(30, 200);
        check_frame(20, 16'd3);

        // Frame 4: frame number forced to 65535 while idle must wrap to 1
        repeat (5) @(posedge clk);
        #1 force dut.r_frame_num = 16'hFFFF;
        #1 release dut.r_frame_num;
        push_frame();
        enable = 1'b1;
        wait_frame_active();
        enable = 1'b0;
        wait_words(40, 200);
        chk("wrap_fs_hand_value", cap_data[30], 32'h1A000100);
        check_frame(30, 16'd1);
        repeat (30) @(posedge clk);
        chk("no_fs_after_wrap_frame", cap_n, 32'd40);
        chk("frame_active_idle_end", {31'h0, frame_active}, 32'h0);
        chk("ack_count_total", ack_n, 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
